// File: rtl/gain_pwm_driver.sv
// PWM output stage: latches coprocessor gain results, slews the applied duty once per
// PWM period and falls back to 0 % when results stop arriving.
module gain_pwm_driver #(
  parameter int unsigned PERIOD_CYCLES   = 1000,
  parameter int unsigned SLEW_STEP       = 5,
  parameter int unsigned TIMEOUT_PERIODS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       valid_in,
  input  logic [7:0] G_in,
  output logic       pwm_out,
  output logic [7:0] duty_cur,
  output logic [7:0] target,
  output logic       update_ack,
  output logic       period_tick,
  output logic       timeout_flag
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAILSAFE
  } state_t;

  localparam logic [15:0]        CNT_LAST  = 16'(PERIOD_CYCLES - 1);
  localparam logic signed [9:0]  SLEW      = 10'(SLEW_STEP);
  localparam logic [7:0]         TMO_LIMIT = 8'(TIMEOUT_PERIODS);
  localparam logic [23:0]        PERIOD_W  = 24'(PERIOD_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] thr_q, thr_d;
  logic [7:0]  duty_q, duty_d;
  logic [7:0]  target_q, target_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        pwm_q, pwm_d;
  logic        ack_q, ack_d;

  logic              tick;
  logic [7:0]        g_clamped;
  logic signed [9:0] duty_s, target_s, diff_s, step_s;
  logic [7:0]        d_next;
  logic [23:0]       thr_prod;

  assign tick      = (cnt_q == CNT_LAST);
  assign g_clamped = (G_in > 8'd100) ? 8'd100 : G_in;

  // Signed headroom keeps duty +/- SLEW from wrapping near 0 and 100.
  always_comb begin : slew_calc
    duty_s   = signed'({2'b00, duty_q});
    target_s = signed'({2'b00, target_q});
    diff_s   = target_s - duty_s;
    if (diff_s > SLEW)       step_s = duty_s + SLEW;
    else if (diff_s < -SLEW) step_s = duty_s - SLEW;
    else                     step_s = target_s;
    if (step_s < 10'sd0)        d_next = '0;
    else if (step_s > 10'sd100) d_next = 8'd100;
    else                        d_next = step_s[7:0];
    thr_prod = 24'(d_next) * PERIOD_W;
  end

  always_comb begin : next_state
    state_d  = state_q;
    cnt_d    = cnt_q;
    thr_d    = thr_q;
    duty_d   = duty_q;
    target_d = target_q;
    tmo_d    = tmo_q;
    pwm_d    = 1'b0;
    ack_d    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      thr_d   = '0;
      duty_d  = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          cnt_d   = '0;
          thr_d   = '0;
          duty_d  = '0;
          tmo_d   = '0;
        end
        RUN, FAILSAFE: begin
          pwm_d = (cnt_q < thr_q);
          cnt_d = tick ? '0 : cnt_q + 16'd1;
          // Slew uses the target held before this edge; a same-cycle capture lands next period.
          if (tick) begin
            duty_d = d_next;
            thr_d  = 16'(thr_prod / 24'd100);
            if (tmo_q < TMO_LIMIT) tmo_d = tmo_q + 8'd1;
          end
          if (valid_in) begin
            target_d = g_clamped;
            tmo_d    = '0;
            ack_d    = 1'b1;
            state_d  = RUN;
          end else if (tick && (tmo_d == TMO_LIMIT)) begin
            state_d  = FAILSAFE;
            target_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      thr_q    <= '0;
      duty_q   <= '0;
      target_q <= '0;
      tmo_q    <= '0;
      pwm_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      thr_q    <= thr_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      tmo_q    <= tmo_d;
      pwm_q    <= pwm_d;
      ack_q    <= ack_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign duty_cur     = duty_q;
  assign target       = target_q;
  assign update_ack   = ack_q;
  assign period_tick  = tick;
  assign timeout_flag = (state_q == FAILSAFE);

endmodule
